bp_gshare: RTL and testbench

Parametrised next-generation branch predictor for the fetch stage. It combines a gshare-indexed PHT of 2-bit saturating counters, a speculative global history register (GHR) with repair on mispredict, and a direct-mapped tagged BTB. IF issues lookups, and results return one cycle later. The issue stage writes back resolved branches on the update port.

---
 rtl/bp_gshare.sv | 129 ++++++++++++
 tb/tb_bp_gshare.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_gshare.sv
// Gshare branch predictor: 2-bit PHT indexed by pc^GHR, speculative GHR with
// mispredict repair, and a direct-mapped tagged BTB. Lookups return one cycle later.
module bp_gshare #(
   parameter int PC_W      = 32,
   parameter int PHT_IDX_W = 10,
   parameter int GHR_W     = 8,
   parameter int BTB_IDX_W = 4,
   parameter int BTB_TAG_W = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid_i,
   input  logic             if_allowin_i,
   input  logic [PC_W-1:0]  req_pc_i,
   input  logic             flush_i,
   output logic             pred_valid_o,
   output logic             pred_taken_o,
   output logic [1:0]       pred_state_o,
   output logic [GHR_W-1:0] pred_ghr_o,
   output logic             btb_hit_o,
   output logic [PC_W-1:0]  pred_target_o,
   input  logic             upd_valid_i,
   input  logic [PC_W-1:0]  upd_pc_i,
   input  logic [GHR_W-1:0] upd_ghr_i,
   input  logic             upd_taken_i,
   input  logic [PC_W-1:0]  upd_target_i,
   input  logic             upd_mispredict_i
);
   localparam int PHT_N  = 1 << PHT_IDX_W;
   localparam int BTB_N  = 1 << BTB_IDX_W;
   localparam int TAG_LO = BTB_IDX_W + 2;

   function automatic logic [1:0] sat_count(input logic [1:0] cnt, input logic taken);
      if (taken) return (cnt == 2'b11) ? cnt : cnt + 2'b01;
      return (cnt == 2'b00) ? cnt : cnt - 2'b01;
   endfunction

   // Shift written without slicing so GHR_W == 1 elaborates cleanly.
   function automatic logic [GHR_W-1:0] hist_push(input logic [GHR_W-1:0] hist, input logic bit_in);
      return (hist << 1) | GHR_W'(bit_in);
   endfunction

   logic [GHR_W-1:0]     ghr;
   logic [1:0]           pht        [PHT_N];
   logic                 btb_valid  [BTB_N];
   logic [BTB_TAG_W-1:0] btb_tag    [BTB_N];
   logic [PC_W-1:0]      btb_target [BTB_N];

   logic                 fire_p0;
   logic [PHT_IDX_W-1:0] pht_idx_p0;
   logic [BTB_IDX_W-1:0] btb_idx_p0;
   logic [BTB_TAG_W-1:0] tag_p0;
   logic [1:0]           state_p0;
   logic                 hit_p0;
   logic [PHT_IDX_W-1:0] upd_pht_idx;
   logic [BTB_IDX_W-1:0] upd_btb_idx;
   logic [BTB_TAG_W-1:0] upd_tag;
   logic                 unused_pc_bits;

   assign fire_p0    = req_valid_i & if_allowin_i;
   assign pht_idx_p0 = req_pc_i[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr);
   assign btb_idx_p0 = req_pc_i[BTB_IDX_W+1:2];
   assign tag_p0     = req_pc_i[TAG_LO+BTB_TAG_W-1:TAG_LO];
   assign state_p0   = pht[pht_idx_p0];
   assign hit_p0     = btb_valid[btb_idx_p0] && (btb_tag[btb_idx_p0] == tag_p0);

   assign upd_pht_idx = upd_pc_i[PHT_IDX_W+1:2] ^ PHT_IDX_W'(upd_ghr_i);
   assign upd_btb_idx = upd_pc_i[BTB_IDX_W+1:2];
   assign upd_tag     = upd_pc_i[TAG_LO+BTB_TAG_W-1:TAG_LO];

   // Byte-offset and high PC bits take no part in indexing or tagging.
   assign unused_pc_bits = ^{req_pc_i, upd_pc_i};

   // Stage p0 -> p1: registered prediction; arrays are read before this edge's writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         pred_valid_o  <= 1'b0;
         pred_taken_o  <= 1'b0;
         pred_state_o  <= 2'b00;
         pred_ghr_o    <= '0;
         btb_hit_o     <= 1'b0;
         pred_target_o <= '0;
      end else begin
         pred_valid_o <= fire_p0 & ~flush_i;
         if (fire_p0) begin
            pred_state_o  <= state_p0;
            pred_ghr_o    <= ghr;
            btb_hit_o     <= hit_p0;
            pred_target_o <= btb_target[btb_idx_p0];
            pred_taken_o  <= hit_p0 & state_p0[1];
         end
      end
   end

   // Repair from a resolved mispredict outranks the speculative shift.
   always_ff @(posedge clk) begin
      if (reset) begin
         ghr <= '0;
      end else if (upd_valid_i && upd_mispredict_i) begin
         ghr <= hist_push(upd_ghr_i, upd_taken_i);
      end else if (pred_valid_o && btb_hit_o) begin
         ghr <= hist_push(ghr, pred_taken_o);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
      end else if (upd_valid_i) begin
         pht[upd_pht_idx] <= sat_count(pht[upd_pht_idx], upd_taken_i);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < BTB_N; i++) btb_valid[i] <= 1'b0;
      end else if (upd_valid_i && upd_taken_i) begin
         btb_valid[upd_btb_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (upd_valid_i && upd_taken_i) begin
         btb_tag[upd_btb_idx]    <= upd_tag;
         btb_target[upd_btb_idx] <= upd_target_i;
      end
   end

endmodule

// File: tb/tb_bp_gshare.sv
// Bench for bp_gshare: directed vector table, hand-written corner sequences,
// and a randomized run checked against an arithmetic reference model.
module tb_bp_gshare;
   localparam int PC_W = 32, PHT_IDX_W = 10, GHR_W = 8, BTB_IDX_W = 4, BTB_TAG_W = 10;
   localparam int PHT_N = 1 << PHT_IDX_W;
   localparam int BTB_N = 1 << BTB_IDX_W;

   logic clk, reset, req_valid_i, if_allowin_i, flush_i;
   logic [PC_W-1:0] req_pc_i;
   logic pred_valid_o, pred_taken_o, btb_hit_o;
   logic [1:0] pred_state_o;
   logic [GHR_W-1:0] pred_ghr_o;
   logic [PC_W-1:0] pred_target_o;
   logic upd_valid_i, upd_taken_i, upd_mispredict_i;
   logic [PC_W-1:0] upd_pc_i, upd_target_i;
   logic [GHR_W-1:0] upd_ghr_i;

   bp_gshare #(.PC_W(PC_W), .PHT_IDX_W(PHT_IDX_W), .GHR_W(GHR_W),
               .BTB_IDX_W(BTB_IDX_W), .BTB_TAG_W(BTB_TAG_W)) dut (
      .clk(clk), .reset(reset), .req_valid_i(req_valid_i), .if_allowin_i(if_allowin_i),
      .req_pc_i(req_pc_i), .flush_i(flush_i), .pred_valid_o(pred_valid_o),
      .pred_taken_o(pred_taken_o), .pred_state_o(pred_state_o), .pred_ghr_o(pred_ghr_o),
      .btb_hit_o(btb_hit_o), .pred_target_o(pred_target_o), .upd_valid_i(upd_valid_i),
      .upd_pc_i(upd_pc_i), .upd_ghr_i(upd_ghr_i), .upd_taken_i(upd_taken_i),
      .upd_target_i(upd_target_i), .upd_mispredict_i(upd_mispredict_i));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit check_model = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Reference model: plain integer state, rules applied once per clock.
   int          m_pht [PHT_N];
   bit          m_bv  [BTB_N];
   int          m_tag [BTB_N];
   logic [31:0] m_tgt [BTB_N];
   int          m_ghr;
   bit          e_valid, e_hit, e_taken;
   int          e_state, e_ghr;
   logic [31:0] e_tgt;

   task automatic model_step();
      int idx, bi, tg, ui, c, ng, l_state, l_ghr;
      bit fire, l_hit;
      logic [31:0] l_tgt;
      if (reset) begin
         for (int i = 0; i < PHT_N; i++) m_pht[i] = 1;
         for (int i = 0; i < BTB_N; i++) m_bv[i] = 0;
         m_ghr = 0; e_valid = 0; e_hit = 0; e_taken = 0; e_state = 0; e_ghr = 0; e_tgt = 0;
         return;
      end
      fire = req_valid_i && if_allowin_i;
      l_state = 0; l_hit = 0; l_tgt = 0; l_ghr = m_ghr;
      if (fire) begin
         idx = ((req_pc_i / 4) % PHT_N) ^ m_ghr;
         bi  = (req_pc_i / 4) % BTB_N;
         tg  = (req_pc_i / (4 * BTB_N)) % (1 << BTB_TAG_W);
         l_state = m_pht[idx];
         l_hit   = m_bv[bi] && (m_tag[bi] == tg);
         l_tgt   = m_tgt[bi];
      end
      ng = m_ghr;
      if (upd_valid_i && upd_mispredict_i) ng = (int'(upd_ghr_i) * 2 + upd_taken_i) % (1 << GHR_W);
      else if (e_valid && e_hit) ng = (m_ghr * 2 + e_taken) % (1 << GHR_W);
      if (upd_valid_i) begin
         ui = ((upd_pc_i / 4) % PHT_N) ^ int'(upd_ghr_i);
         c  = m_pht[ui];
         m_pht[ui] = upd_taken_i ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
         if (upd_taken_i) begin
            bi = (upd_pc_i / 4) % BTB_N;
            m_bv[bi]  = 1;
            m_tag[bi] = (upd_pc_i / (4 * BTB_N)) % (1 << BTB_TAG_W);
            m_tgt[bi] = upd_target_i;
         end
      end
      e_valid = fire && !flush_i;
      if (fire) begin
         e_state = l_state; e_hit = l_hit; e_tgt = l_tgt; e_ghr = l_ghr;
         e_taken = l_hit && (l_state >= 2);
      end
      m_ghr = ng;
   endtask

   task automatic model_check();
      chk("rand valid", pred_valid_o, e_valid);
      if (e_valid) begin
         chk("rand state", pred_state_o, e_state);
         chk("rand hit", btb_hit_o, e_hit);
         chk("rand taken", pred_taken_o, e_taken);
         chk("rand ghr", pred_ghr_o, e_ghr);
         if (e_hit) chk("rand target", pred_target_o, e_tgt);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      if (check_model) model_check();
   endtask

   task automatic clear_inputs();
      req_valid_i = 0; if_allowin_i = 1; req_pc_i = 0; flush_i = 0;
      upd_valid_i = 0; upd_pc_i = 0; upd_ghr_i = 0; upd_taken_i = 0;
      upd_target_i = 0; upd_mispredict_i = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1; tick(); tick(); reset = 0;
   endtask

   task automatic upd(input logic [31:0] pc, input logic [7:0] g, input bit t,
                      input logic [31:0] tgt, input bit mp);
      upd_valid_i = 1; upd_pc_i = pc; upd_ghr_i = g; upd_taken_i = t;
      upd_target_i = tgt; upd_mispredict_i = mp;
      tick();
      upd_valid_i = 0; upd_mispredict_i = 0;
   endtask

   task automatic lookup(input logic [31:0] pc);
      req_valid_i = 1; req_pc_i = pc;
      tick();
      req_valid_i = 0;
   endtask

   typedef struct {
      bit req; bit al; logic [31:0] pc; bit fl;
      bit upd; logic [31:0] upc; logic [7:0] ug; bit ut; logic [31:0] utg; bit mp;
      bit ev; logic [1:0] es; bit eh; bit et; logic [31:0] etg; logic [7:0] eg;
   } vec_t;

   function automatic vec_t row(bit req, bit al, logic [31:0] pc, bit fl, bit u,
                                logic [31:0] upc, logic [7:0] ug, bit ut, logic [31:0] utg,
                                bit mp, bit ev, logic [1:0] es, bit eh, bit et,
                                logic [31:0] etg, logic [7:0] eg);
      vec_t v;
      v.req = req; v.al = al; v.pc = pc; v.fl = fl; v.upd = u; v.upc = upc; v.ug = ug;
      v.ut = ut; v.utg = utg; v.mp = mp; v.ev = ev; v.es = es; v.eh = eh; v.et = et;
      v.etg = etg; v.eg = eg;
      return v;
   endfunction

   localparam int NV = 17;
   vec_t tbl [NV];

   initial begin
      clear_inputs();
      reset = 1;

      // Reset state
      do_reset();
      chk("reset valid", pred_valid_o, 0);
      chk("reset taken", pred_taken_o, 0);
      chk("reset state", pred_state_o, 0);
      chk("reset ghr", pred_ghr_o, 0);
      chk("reset hit", btb_hit_o, 0);
      chk("reset target", pred_target_o, 0);

      //            req al pc            fl upd upc           ug   ut utg           mp  ev es    eh et etg           eg
      tbl[0]  = row(1, 1, 32'h1c000000, 0, 0, 32'h0,        8'h0, 0, 32'h0,        0,  1, 2'b01, 0, 0, 32'h0,        8'h00);
      tbl[1]  = row(0, 1, 32'h0,        0, 1, 32'h1c000010, 8'h0, 1, 32'h1c000100, 0,  0, 2'b00, 0, 0, 32'h0,        8'h00);
      tbl[2]  = row(0, 1, 32'h0,        0, 1, 32'h1c000010, 8'h0, 1, 32'h1c000100, 0,  0, 2'b00, 0, 0, 32'h0,        8'h00);
      tbl[3]  = row(1, 1, 32'h1c000010, 0, 0, 32'h0,        8'h0, 0, 32'h0,        0,  1, 2'b11, 1, 1, 32'h1c000100, 8'h00);
      tbl[4]  = row(1, 1, 32'h1c000000, 0, 0, 32'h0,        8'h0, 0, 32'h0,        0,  1, 2'b01, 0, 0, 32'h0,        8'h00);
      tbl[5]  = row(1, 1, 32'h1c000000, 0, 0, 32'h0,        8'h0, 0, 32'h0,        0,  1, 2'b01, 0, 0, 32'h0,        8'h01);
      tbl[6]  = row(1, 1, 32'h1c000020, 0, 1, 32'h1c000024, 8'h0, 1, 32'h1c000200, 0,  1, 2'b01, 0, 0, 32'h0,        8'h01);
      tbl[7]  = row(1, 1, 32'h1c000020, 0, 0, 32'h0,        8'h0, 0, 32'h0,        0,  1, 2'b10, 0, 0, 32'h0,        8'h01);
      tbl[8]  = row(1, 1, 32'h1c000030, 0, 1, 32'h1c000030, 8'h0, 1, 32'h1c000300, 0,  1, 2'b01, 0, 0, 32'h0,        8'h01);
      tbl[9]  = row(1, 1, 32'h1c000030, 0, 0, 32'h0,        8'h0, 0, 32'h0,        0,  1, 2'b01, 1, 0, 32'h1c000300, 8'h01);
      tbl[10] = row(0, 1, 32'h0,        0, 0, 32'h0,        8'h0, 0, 32'h0,        0,  0, 2'b00, 0, 0, 32'h0,        8'h00);
      tbl[11] = row(1, 1, 32'h1c000000, 0, 0, 32'h0,        8'h0, 0, 32'h0,        0,  1, 2'b01, 0, 0, 32'h0,        8'h02);
      tbl[12] = row(1, 1, 32'h1c000010, 1, 0, 32'h0,        8'h0, 0, 32'h0,        0,  0, 2'b00, 0, 0, 32'h0,        8'h00);
      tbl[13] = row(0, 1, 32'h0,        0, 0, 32'h0,        8'h0, 0, 32'h0,        0,  0, 2'b00, 0, 0, 32'h0,        8'h00);
      tbl[14] = row(1, 1, 32'h1c000000, 0, 0, 32'h0,        8'h0, 0, 32'h0,        0,  1, 2'b01, 0, 0, 32'h0,        8'h02);
      tbl[15] = row(1, 0, 32'h1c000010, 0, 0, 32'h0,        8'h0, 0, 32'h0,        0,  0, 2'b00, 0, 0, 32'h0,        8'h00);
      tbl[16] = row(1, 1, 32'h1c000000, 0, 0, 32'h0,        8'h0, 0, 32'h0,        0,  1, 2'b01, 0, 0, 32'h0,        8'h02);

      for (int r = 0; r < NV; r++) begin
         req_valid_i = tbl[r].req; if_allowin_i = tbl[r].al; req_pc_i = tbl[r].pc;
         flush_i = tbl[r].fl; upd_valid_i = tbl[r].upd; upd_pc_i = tbl[r].upc;
         upd_ghr_i = tbl[r].ug; upd_taken_i = tbl[r].ut; upd_target_i = tbl[r].utg;
         upd_mispredict_i = tbl[r].mp;
         tick();
         chk($sformatf("row%0d valid", r), pred_valid_o, tbl[r].ev);
         if (tbl[r].ev) begin
            chk($sformatf("row%0d state", r), pred_state_o, tbl[r].es);
            chk($sformatf("row%0d hit", r), btb_hit_o, tbl[r].eh);
            chk($sformatf("row%0d taken", r), pred_taken_o, tbl[r].et);
            chk($sformatf("row%0d ghr", r), pred_ghr_o, tbl[r].eg);
            if (tbl[r].eh) chk($sformatf("row%0d target", r), pred_target_o, tbl[r].etg);
         end
      end
      clear_inputs();

      // Counter saturation at both ends
      do_reset();
      repeat (4) upd(32'h1c000040, 8'h00, 0, 32'h0, 0);
      lookup(32'h1c000040);
      chk("sat0 valid", pred_valid_o, 1);
      chk("sat0 state", pred_state_o, 2'b00);
      upd(32'h1c000040, 8'h00, 0, 32'h0, 0);
      lookup(32'h1c000040);
      chk("sat0 hold", pred_state_o, 2'b00);
      repeat (4) upd(32'h1c000040, 8'h00, 1, 32'h1c000400, 0);
      lookup(32'h1c000040);
      chk("sat3 state", pred_state_o, 2'b11);
      chk("sat3 hit", btb_hit_o, 1);
      chk("sat3 taken", pred_taken_o, 1);
      tick();
      upd(32'h1c000044, 8'h01, 1, 32'h1c000500, 0);
      lookup(32'h1c000044);
      chk("sat3 hold", pred_state_o, 2'b11);
      chk("sat3 ghr", pred_ghr_o, 8'h01);
      chk("sat3 target", pred_target_o, 32'h1c000500);

      // Repair wins over a same-cycle speculative shift
      do_reset();
      repeat (2) upd(32'h1c000010, 8'h00, 1, 32'h1c000100, 0);
      lookup(32'h1c000010);
      chk("repair setup hit", btb_hit_o, 1);
      upd(32'h1c000080, 8'h5a, 0, 32'h0, 1);
      lookup(32'h1c000000);
      chk("repair ghr", pred_ghr_o, 8'hb4);
      chk("repair state", pred_state_o, 2'b01);

      // Reset during back-to-back lookups
      req_valid_i = 1; req_pc_i = 32'h1c000010;
      tick();
      chk("b2b hit 1", btb_hit_o, 1);
      tick();
      chk("b2b hit 2", btb_hit_o, 1);
      reset = 1;
      tick();
      chk("midreset valid", pred_valid_o, 0);
      chk("midreset hit", btb_hit_o, 0);
      reset = 0;
      tick();
      chk("postreset valid", pred_valid_o, 1);
      chk("postreset hit", btb_hit_o, 0);
      chk("postreset state", pred_state_o, 2'b01);
      chk("postreset ghr", pred_ghr_o, 8'h00);
      clear_inputs();

      // Randomized run against the reference model
      do_reset();
      check_model = 1;
      for (int n = 0; n < 3000; n++) begin
         reset            = ($urandom_range(0, 399) == 0);
         req_valid_i      = ($urandom_range(0, 9) < 7);
         if_allowin_i     = ($urandom_range(0, 9) < 8);
         req_pc_i         = 32'h1c000000 + ($urandom_range(0, 255) * 4);
         flush_i          = ($urandom_range(0, 9) == 0);
         upd_valid_i      = $urandom_range(0, 1);
         upd_pc_i         = 32'h1c000000 + ($urandom_range(0, 255) * 4);
         upd_ghr_i        = 8'($urandom_range(0, 255));
         upd_taken_i      = $urandom_range(0, 1);
         upd_target_i     = $urandom;
         upd_mispredict_i = ($urandom_range(0, 3) == 0);
         tick();
      end
      check_model = 0;
      reset = 0;
      clear_inputs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
